// File: rtl/dff_chain_loader.sv
// Serially loads a master-slave DFF chain from a parallel word (MSB first),
// strobes latch, and returns the bits seen on sdi as a readback word.
module dff_chain_loader #(
    parameter int WIDTH = 8,
    parameter int DIV   = 2,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             abort,
    output logic             sdo,
    output logic             shift_en,
    input  logic             sdi,
    output logic             latch,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rd_data
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH,
        S_GAP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] rx;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             tick;

    // Last cycle of each bit; abort in that cycle must not clock the chain.
    assign tick       = (state == S_SHIFT) && (div_cnt == '0);
    assign shift_en   = tick && !abort;
    assign sdo        = (state == S_SHIFT) && shreg[WIDTH-1];
    assign load_ready = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign latch      = (state == S_LATCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            shreg   <= '0;
            rx      <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            gap_cnt <= '0;
            done    <= 1'b0;
            rd_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_valid) begin
                        shreg   <= load_data;
                        rx      <= '0;
                        bit_cnt <= BIT_LAST;
                        div_cnt <= DIV_LAST;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (tick) begin
                        shreg   <= {shreg[WIDTH-2:0], 1'b0};
                        rx      <= {rx[WIDTH-2:0], sdi};
                        div_cnt <= DIV_LAST;
                        if (bit_cnt == '0) begin
                            state <= S_LATCH;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                S_LATCH: begin
                    rd_data <= rx;
                    done    <= 1'b1;
                    if (GAP > 0) begin
                        gap_cnt <= GAP_LAST;
                        state   <= S_GAP;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dff_chain_loader.sv
// Directed bench for dff_chain_loader: a DIV=2/GAP=1 instance with a one-flop
// loopback chain, plus a DIV=1/GAP=0 instance for the fastest shift rate.
module tb_dff_chain_loader;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] load_data_a, rd_a;
    logic load_valid_a, load_ready_a, abort_a, sdo_a, shift_en_a, sdi_a;
    logic latch_a, busy_a, done_a;
    logic sdi_q, loop_en, sdi_c;

    logic [7:0] load_data_b, rd_b;
    logic load_valid_b, load_ready_b, abort_b, sdo_b, shift_en_b, sdi_b;
    logic latch_b, busy_b, done_b;

    always @(posedge clk) sdi_q <= sdo_a;
    assign sdi_a = loop_en ? sdi_q : sdi_c;

    dff_chain_loader #(.WIDTH(8), .DIV(2), .GAP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .load_data(load_data_a), .load_valid(load_valid_a),
        .load_ready(load_ready_a), .abort(abort_a), .sdo(sdo_a), .shift_en(shift_en_a),
        .sdi(sdi_a), .latch(latch_a), .busy(busy_a), .done(done_a), .rd_data(rd_a)
    );

    dff_chain_loader #(.WIDTH(8), .DIV(1), .GAP(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .load_data(load_data_b), .load_valid(load_valid_b),
        .load_ready(load_ready_b), .abort(abort_b), .sdo(sdo_b), .shift_en(shift_en_b),
        .sdi(sdi_b), .latch(latch_b), .busy(busy_b), .done(done_b), .rd_data(rd_b)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready_a();
        int n = 0;
        @(negedge clk);
        while (!load_ready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_accept", load_ready_a, 1);
    endtask

    // Accept edge E0 precedes cycle 1; checks follow the 8-bit, DIV=2 timeline.
    task automatic xfer_a(input logic [7:0] d, input bit noise, input logic [7:0] exp_rd);
        int idx;
        wait_ready_a();
        load_data_a  = d;
        load_valid_a = 1'b1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            idx = 7 - (cyc - 1) / 2;
            chk($sformatf("sdo_c%0d", cyc), sdo_a, d[idx]);
            chk($sformatf("shift_en_c%0d", cyc), shift_en_a, (cyc % 2 == 0));
            chk($sformatf("ready_c%0d", cyc), load_ready_a, 0);
            load_valid_a = noise && (cyc < 15) && (cyc % 2 == 1);
            load_data_a  = noise ? 8'h55 : d;
        end
        load_valid_a = 1'b0;
        @(negedge clk);
        chk("latch_c17", latch_a, 1);
        chk("shift_en_c17", shift_en_a, 0);
        chk("done_c17", done_a, 0);
        @(negedge clk);
        chk("done_c18", done_a, 1);
        chk("latch_c18", latch_a, 0);
        chk("rd_data_c18", rd_a, exp_rd);
        chk("ready_c18", load_ready_a, 0);
        @(negedge clk);
        chk("ready_c19", load_ready_a, 1);
        chk("busy_c19", busy_a, 0);
        chk("done_c19", done_a, 0);
    endtask

    task automatic abort_a_at(input logic [7:0] d, input int ac, input logic [7:0] prev);
        bit pulse = 1'b0;
        wait_ready_a();
        load_data_a  = d;
        load_valid_a = 1'b1;
        @(negedge clk);
        load_valid_a = 1'b0;
        for (int c = 2; c <= ac; c++) @(negedge clk);
        abort_a = 1'b1;
        #1;
        chk($sformatf("abort%0d_shift_en", ac), shift_en_a, 0);
        chk($sformatf("abort%0d_busy", ac), busy_a, 1);
        @(posedge clk);
        #1 abort_a = 1'b0;
        @(negedge clk);
        chk($sformatf("abort%0d_idle", ac), load_ready_a, 1);
        for (int c = 0; c < 20; c++) begin
            pulse |= latch_a | done_a;
            @(negedge clk);
        end
        chk($sformatf("abort%0d_no_pulse", ac), pulse, 0);
        chk($sformatf("abort%0d_rd_kept", ac), rd_a, prev);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         loop;
        bit         sdi_v;
        bit         noise;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C};
        vecs[2] = '{8'hA5, 1'b0, 1'b1, 1'b0, 8'hFF};
        vecs[3] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[4] = '{8'h96, 1'b1, 1'b0, 1'b0, 8'h96};

        rst_n = 1'b0;
        load_data_a = 8'h00; load_valid_a = 1'b0; abort_a = 1'b0;
        load_data_b = 8'h00; load_valid_b = 1'b0; abort_b = 1'b0; sdi_b = 1'b0;
        loop_en = 1'b0; sdi_c = 1'b0;
        #12;
        chk("rst_ready", load_ready_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_sdo", sdo_a, 0);
        chk("rst_shift_en", shift_en_a, 0);
        chk("rst_latch", latch_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_rd", rd_a, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            loop_en = vecs[i].loop;
            sdi_c   = vecs[i].sdi_v;
            xfer_a(vecs[i].data, vecs[i].noise, vecs[i].exp_rd);
        end

        // Held valid: second word taken on the first IDLE cycle after GAP.
        loop_en = 1'b1;
        wait_ready_a();
        load_data_a  = 8'h3C;
        load_valid_a = 1'b1;
        @(negedge clk);
        load_data_a = 8'hFF;
        for (int c = 2; c <= 18; c++) @(negedge clk);
        chk("b2b_done1", done_a, 1);
        chk("b2b_rd1", rd_a, 8'h3C);
        @(negedge clk);
        chk("b2b_ready19", load_ready_a, 1);
        @(negedge clk);
        chk("b2b_busy20", busy_a, 1);
        load_valid_a = 1'b0;
        repeat (17) @(negedge clk);
        chk("b2b_done2", done_a, 1);
        chk("b2b_rd2", rd_a, 8'hFF);

        abort_a_at(8'hA5, 7, 8'hFF);
        abort_a_at(8'hA5, 8, 8'hFF);
        xfer_a(8'h5A, 1'b0, 8'h5A);

        // Asynchronous reset between edges, mid-SHIFT.
        wait_ready_a();
        load_data_a  = 8'hA5;
        load_valid_a = 1'b1;
        @(negedge clk);
        load_valid_a = 1'b0;
        repeat (4) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ready", load_ready_a, 1);
        chk("arst_busy", busy_a, 0);
        chk("arst_shift_en", shift_en_a, 0);
        chk("arst_sdo", sdo_a, 0);
        chk("arst_rd", rd_a, 0);
        chk("arst_latch", latch_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        xfer_a(8'h81, 1'b0, 8'h81);

        // DIV=1, GAP=0 instance.
        @(negedge clk);
        chk("b_ready", load_ready_b, 1);
        load_data_b  = 8'h01;
        load_valid_b = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            load_valid_b = 1'b0;
            chk($sformatf("b_shift_en_c%0d", c), shift_en_b, 1);
            chk($sformatf("b_sdo_c%0d", c), sdo_b, (c == 8));
        end
        @(negedge clk);
        chk("b_latch_c9", latch_b, 1);
        chk("b_shift_en_c9", shift_en_b, 0);
        @(negedge clk);
        chk("b_done_c10", done_b, 1);
        chk("b_ready_c10", load_ready_b, 1);
        chk("b_rd_c10", rd_b, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
